vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 79 +++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA horizontal/vertical timing with registered sync, active and pixel coordinates
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit H_POL = 1'b0,
  parameter bit V_POL = 1'b0,
  parameter int CW = 12,
  parameter int FW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          restart,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_tc,
  output logic          frame_tc,
  output logic [FW-1:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_END = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_END = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_ON = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic vis;
  // terminal counts are suppressed by restart and reset so nothing downstream sees a spurious wrap
  always_comb begin
    line_tc = reset_n && en && !restart && hcount == H_END;
    frame_tc = line_tc && vcount == V_END;
    vis = hcount < H_VIS && vcount < V_VIS;
  end
  // position and frame counters, advancing on enabled pixel clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
      frame_cnt <= '0;
    end else if (restart) begin
      hcount <= '0;
      vcount <= '0;
    end else if (en) begin
      hcount <= line_tc ? '0 : hcount + 1'b1;
      if (line_tc) vcount <= frame_tc ? '0 : vcount + 1'b1;
      if (frame_tc) frame_cnt <= frame_cnt + 1'b1;
    end
  end
  // video outputs sampled from the pre-edge position every clock, giving one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      active <= 1'b0;
      x <= '0;
      y <= '0;
    end else begin
      hsync <= (hcount >= HS_ON && hcount < HS_OFF) ? H_POL : ~H_POL;
      vsync <= (vcount >= VS_ON && vcount < VS_OFF) ? V_POL : ~V_POL;
      active <= vis;
      x <= vis ? hcount : '0;
      y <= vis ? vcount : '0;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen with an 8x6 miniature timing
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset_n, en, restart;
  logic [3:0] hcount, vcount, x, y;
  logic hsync, vsync, active, line_tc, frame_tc;
  logic [1:0] frame_cnt;
  int checks = 0;
  int errors = 0;
  logic [3:0] mh = '0, mv = '0, ph, pv;
  logic [1:0] mf = '0;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(4), .FW(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .restart(restart),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .active(active), .x(x), .y(y), .line_tc(line_tc), .frame_tc(frame_tc),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic adv(input logic e, input logic r);
    if (r) begin
      mh = '0;
      mv = '0;
    end else if (e) begin
      if (mh == 4'd7) begin
        mh = '0;
        if (mv == 4'd5) begin
          mv = '0;
          mf = mf + 2'd1;
        end else mv = mv + 4'd1;
      end else mh = mh + 4'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en = 1'b0;
    restart = 1'b0;
    #12;
    checks++;
    if ({hcount, vcount, frame_cnt, x, y} !== 18'd0 || active !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || line_tc !== 1'b0 || frame_tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_state h=%0d v=%0d f=%0d x=%0d y=%0d act=%b hs=%b vs=%b ltc=%b ftc=%b want all 0, hs=vs=1", hcount, vcount, frame_cnt, x, y, active, hsync, vsync, line_tc, frame_tc);
    end
    tick();
    reset_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_count();
    int ftc = 0;
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (hcount !== mh || vcount !== mv || line_tc !== (mh == 4'd7) || frame_tc !== (mh == 4'd7 && mv == 4'd5)) begin
        errors++;
        $display("FAIL count cyc=%0d h=%0d v=%0d ltc=%b ftc=%b want h=%0d v=%0d ltc=%b ftc=%b", i, hcount, vcount, line_tc, frame_tc, mh, mv, mh == 4'd7, mh == 4'd7 && mv == 4'd5);
      end
      if (frame_tc) ftc++;
      tick();
      adv(1'b1, 1'b0);
    end
    checks++;
    if (ftc != 1 || frame_cnt !== 2'd1 || hcount !== 4'd0 || vcount !== 4'd0) begin
      errors++;
      $display("FAIL frame_end ftc=%0d f=%0d h=%0d v=%0d want 1 1 0 0", ftc, frame_cnt, hcount, vcount);
    end
  endtask

  task automatic test_sync();
    logic ea;
    for (int i = 0; i < 48; i++) begin
      ph = mh;
      pv = mv;
      tick();
      adv(1'b1, 1'b0);
      ea = ph < 4'd4 && pv < 4'd3;
      checks++;
      if (hsync !== !(ph == 4'd5 || ph == 4'd6) || vsync !== (pv != 4'd4) || active !== ea || x !== (ea ? ph : 4'd0) || y !== (ea ? pv : 4'd0)) begin
        errors++;
        $display("FAIL sync at h=%0d v=%0d hs=%b vs=%b act=%b x=%0d y=%0d want hs=%b vs=%b act=%b x=%0d y=%0d", ph, pv, hsync, vsync, active, x, y, !(ph == 4'd5 || ph == 4'd6), pv != 4'd4, ea, ea ? ph : 4'd0, ea ? pv : 4'd0);
      end
    end
  endtask

  task automatic test_en_toggle();
    int ftc = 0;
    logic [1:0] f0 = mf;
    for (int i = 0; i < 96; i++) begin
      en = (i % 2 == 0);
      #1;
      checks++;
      if (hcount !== mh || vcount !== mv || line_tc !== (en && mh == 4'd7) || frame_tc !== (en && mh == 4'd7 && mv == 4'd5)) begin
        errors++;
        $display("FAIL en_toggle cyc=%0d en=%b h=%0d v=%0d ltc=%b ftc=%b want h=%0d v=%0d", i, en, hcount, vcount, line_tc, frame_tc, mh, mv);
      end
      if (frame_tc) ftc++;
      tick();
      adv(en, 1'b0);
    end
    en = 1'b1;
    checks++;
    if (ftc != 1 || frame_cnt !== f0 + 2'd1 || hcount !== 4'd0 || vcount !== 4'd0) begin
      errors++;
      $display("FAIL en_toggle_end ftc=%0d f=%0d h=%0d v=%0d want 1 %0d 0 0", ftc, frame_cnt, hcount, vcount, f0 + 2'd1);
    end
  endtask

  task automatic test_restart();
    logic [1:0] f0 = mf;
    for (int i = 0; i < 29; i++) begin
      tick();
      adv(1'b1, 1'b0);
    end
    checks++;
    if (hcount !== 4'd5 || vcount !== 4'd3) begin
      errors++;
      $display("FAIL restart_pre h=%0d v=%0d want 5 3", hcount, vcount);
    end
    restart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      adv(1'b1, 1'b1);
      checks++;
      if (hcount !== 4'd0 || vcount !== 4'd0 || frame_cnt !== f0 || line_tc !== 1'b0) begin
        errors++;
        $display("FAIL restart_hold cyc=%0d h=%0d v=%0d f=%0d ltc=%b want 0 0 %0d 0", i, hcount, vcount, frame_cnt, line_tc, f0);
      end
    end
    restart = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      adv(1'b1, 1'b0);
    end
    restart = 1'b1;
    #1;
    checks++;
    if (hcount !== 4'd7 || line_tc !== 1'b0 || frame_tc !== 1'b0) begin
      errors++;
      $display("FAIL restart_tc h=%0d ltc=%b ftc=%b want 7 0 0", hcount, line_tc, frame_tc);
    end
    tick();
    adv(1'b1, 1'b1);
    restart = 1'b0;
    checks++;
    if (hcount !== 4'd0 || vcount !== 4'd0) begin
      errors++;
      $display("FAIL restart_at_end h=%0d v=%0d want 0 0", hcount, vcount);
    end
  endtask

  task automatic test_wrap();
    for (int fr = 0; fr < 4; fr++) begin
      for (int i = 0; i < 48; i++) begin
        tick();
        adv(1'b1, 1'b0);
      end
      checks++;
      if (frame_cnt !== mf || hcount !== 4'd0 || vcount !== 4'd0) begin
        errors++;
        $display("FAIL wrap frame=%0d f=%0d h=%0d v=%0d want %0d 0 0", fr, frame_cnt, hcount, vcount, mf);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (hcount !== 4'd3 || active !== 1'b1 || x !== 4'd2 || frame_cnt === 2'd0) begin
      errors++;
      $display("FAIL pre_reset h=%0d act=%b x=%0d f=%0d want 3 1 2 nonzero", hcount, active, x, frame_cnt);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({hcount, vcount, frame_cnt, x, y} !== 18'd0 || active !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || line_tc !== 1'b0) begin
      errors++;
      $display("FAIL async_reset h=%0d v=%0d f=%0d x=%0d y=%0d act=%b hs=%b vs=%b want reset values", hcount, vcount, frame_cnt, x, y, active, hsync, vsync);
    end
    tick();
    tick();
    checks++;
    if (hcount !== 4'd0 || frame_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold h=%0d f=%0d want 0 0", hcount, frame_cnt);
    end
    #2;
    reset_n = 1'b1;
    #1;
    checks++;
    if (hcount !== 4'd0) begin
      errors++;
      $display("FAIL reset_release h=%0d want 0", hcount);
    end
    tick();
    tick();
    checks++;
    if (hcount !== 4'd2 || vcount !== 4'd0) begin
      errors++;
      $display("FAIL post_reset h=%0d v=%0d want 2 0", hcount, vcount);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_sync();
    test_en_toggle();
    test_restart();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
